multi_literal_match_engine: RTL and testbench

- Runtime-programmable successor to the fixed per-rule chain-of-flops string engines in the payload engine.
- Consumes one raw payload byte per enabled cycle and tracks NUM_ALT alternative literal strings (up to MAX_LEN bytes each) with a shift-chain NFA per alternative.
- Adds what the fixed engines lack:
  - pattern loading without resynthesis;
  - per-alternative length;
  - case-insensitive and anchored modes;
  - a match pulse identifying which alternative hit, the offset of the first match, and a saturating match count.
- Sits beside the fixed engines; its sticky `out` feeds the same rule-result collector.

---
 rtl/multi_literal_match_engine.sv | 130 +++++++++++++
 tb/tb_multi_literal_match_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_literal_match_engine.sv
// Runtime-programmable multi-alternative literal matcher: one shift-chain NFA per alternative,
// fed one payload byte per enabled cycle, with match pulse, first-match offset and hit counter.
module multi_literal_match_engine #(
  parameter int unsigned NUM_ALT = 2,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned OFF_W   = 16,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned AltW   = (NUM_ALT > 1) ? $clog2(NUM_ALT) : 1,
  localparam int unsigned PosW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned LenW   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sod,
  input  logic               en,
  input  logic [7:0]         data,
  input  logic               cfg_we,
  input  logic [AltW-1:0]    cfg_alt,
  input  logic [PosW-1:0]    cfg_pos,
  input  logic [7:0]         cfg_char,
  input  logic               cfg_len_we,
  input  logic [LenW-1:0]    cfg_len,
  input  logic               cfg_nocase,
  input  logic               cfg_anchor,
  output logic               out,
  output logic               match_pulse,
  output logic [NUM_ALT-1:0] match_alt,
  output logic [OFF_W-1:0]   match_off,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [NUM_ALT-1:0][MAX_LEN-1:0][7:0] pat_q, pat_d;
  logic [NUM_ALT-1:0][LenW-1:0]         len_q, len_d;
  logic [NUM_ALT-1:0][MAX_LEN-1:0]      s_q, s_d, shift_n;
  logic [NUM_ALT-1:0]                   done_q, done_d, tail, clr;
  logic [OFF_W-1:0]                     off_q, off_d, match_off_q, match_off_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 out_q, out_d;
  logic                                 accept, pulse_d, alt_ok, pos_ok, len_ok;

  function automatic logic [7:0] fold(input logic [7:0] c, input logic nocase);
    if (nocase && c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
    return c;
  endfunction

  assign accept = en & ~sod;
  assign alt_ok = 32'(cfg_alt) < NUM_ALT;
  assign pos_ok = 32'(cfg_pos) < MAX_LEN;
  assign len_ok = 32'(cfg_len) <= MAX_LEN;

  // Pattern and length storage
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    clr   = '0;
    if (cfg_we && alt_ok && pos_ok) pat_d[cfg_alt][cfg_pos] = cfg_char;
    if (cfg_len_we && alt_ok && len_ok) begin
      len_d[cfg_alt] = cfg_len;
      clr[cfg_alt]   = 1'b1;
    end
  end

  // NFA advance and completion detect
  always_comb begin
    shift_n = '0;
    tail    = '0;
    done_d  = '0;
    s_d     = s_q;
    for (int a = 0; a < int'(NUM_ALT); a++) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        if (fold(data, cfg_nocase) == fold(pat_q[a][i], cfg_nocase)) begin
          if (i == 0) shift_n[a][i] = ~cfg_anchor | (off_q == '0);
          else        shift_n[a][i] = s_q[a][i-1];
        end
        if (32'(len_q[a]) == i + 1) tail[a] = shift_n[a][i];
      end
      // A length rewrite on the same edge overrides the byte for that alternative
      done_d[a] = accept & (len_q[a] != '0) & tail[a] & ~clr[a];
      if (sod || clr[a]) s_d[a] = '0;
      else if (accept)   s_d[a] = shift_n[a];
    end
  end

  assign pulse_d = |done_d;

  always_comb begin
    off_d       = off_q;
    out_d       = out_q | pulse_d;
    match_off_d = match_off_q;
    cnt_d       = cnt_q;
    if (accept && off_q != '1) off_d = off_q + 1'b1;
    if (pulse_d && !out_q)     match_off_d = off_q;
    if (pulse_d && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (sod) begin
      off_d       = '0;
      out_d       = 1'b0;
      match_off_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= '0;
      len_q       <= '0;
      s_q         <= '0;
      done_q      <= '0;
      off_q       <= '0;
      out_q       <= 1'b0;
      match_off_q <= '0;
      cnt_q       <= '0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      s_q         <= s_d;
      done_q      <= done_d;
      off_q       <= off_d;
      out_q       <= out_d;
      match_off_q <= match_off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_pulse = |done_q;
  assign match_alt   = done_q;
  assign match_off   = match_off_q;
  assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_multi_literal_match_engine.sv
// Table-driven bench for multi_literal_match_engine; a second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_multi_literal_match_engine;

  logic        clk = 1'b0;
  logic        rst_n, sod, en, cfg_we, cfg_len_we, cfg_nocase, cfg_anchor;
  logic [7:0]  data, cfg_char;
  logic [0:0]  cfg_alt;
  logic [3:0]  cfg_pos;
  logic [4:0]  cfg_len;
  logic        out, match_pulse, out2, pulse2;
  logic [1:0]  match_alt, alt2;
  logic [15:0] match_off, off2;
  logic [7:0]  match_cnt;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sod;
    logic       en;
    logic [7:0] data;
    logic [1:0] exp_alt;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  multi_literal_match_engine dut (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .data(data),
    .cfg_we(cfg_we), .cfg_alt(cfg_alt), .cfg_pos(cfg_pos), .cfg_char(cfg_char),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_nocase(cfg_nocase),
    .cfg_anchor(cfg_anchor), .out(out), .match_pulse(match_pulse),
    .match_alt(match_alt), .match_off(match_off), .match_cnt(match_cnt)
  );

  multi_literal_match_engine #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .data(data),
    .cfg_we(cfg_we), .cfg_alt(cfg_alt), .cfg_pos(cfg_pos), .cfg_char(cfg_char),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_nocase(cfg_nocase),
    .cfg_anchor(cfg_anchor), .out(out2), .match_pulse(pulse2),
    .match_alt(alt2), .match_off(off2), .match_cnt(cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte slot: expected alt mask queued at drive time, compared once the DUT responds
  task automatic step(input logic s_sod, input logic s_en, input logic [7:0] d,
                      input logic [1:0] e);
    logic [1:0] got;
    sod = s_sod;
    en  = s_en;
    data = d;
    exp_q.push_back(e);
    tick();
    sod = 1'b0;
    en  = 1'b0;
    cfg_we = 1'b0;
    cfg_len_we = 1'b0;
    got = exp_q.pop_front();
    check("match_alt", 32'(match_alt), 32'(got));
    check("match_pulse", 32'(match_pulse), 32'(|got));
  endtask

  // '^' = sod cycle (with a stray byte), '_' = idle cycle; expected '.', '1', '2', '3'
  function automatic void add(input string s, input string e);
    vec_t v;
    for (int i = 0; i < s.len(); i++) begin
      v.sod = (s[i] == "^");
      v.en  = (s[i] != "_");
      v.data = (s[i] == "^") ? 8'h61 : (s[i] == "_") ? 8'h3C : s[i];
      v.exp_alt = (e[i] == "1") ? 2'd1 : (e[i] == "2") ? 2'd2 : (e[i] == "3") ? 2'd3 : 2'd0;
      tbl.push_back(v);
    end
  endfunction

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].sod, tbl[i].en, tbl[i].data, tbl[i].exp_alt);
    tbl.delete();
  endtask

  task automatic set_len(input int alt, input int len);
    cfg_len_we = 1'b1;
    cfg_alt = alt[0:0];
    cfg_len = len[4:0];
    tick();
    cfg_len_we = 1'b0;
  endtask

  task automatic prog(input int alt, input string p);
    for (int i = 0; i < p.len(); i++) begin
      cfg_we = 1'b1;
      cfg_alt = alt[0:0];
      cfg_pos = i[3:0];
      cfg_char = p[i];
      tick();
    end
    cfg_we = 1'b0;
    set_len(alt, p.len());
  endtask

  task automatic check_state(input string tag, input logic o, input int off, input int cnt);
    check({tag, " out"}, 32'(out), 32'(o));
    check({tag, " match_off"}, 32'(match_off), off);
    check({tag, " match_cnt"}, 32'(match_cnt), cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sod = 1'b0; en = 1'b0; data = '0;
    cfg_we = 1'b0; cfg_alt = '0; cfg_pos = '0; cfg_char = '0;
    cfg_len_we = 1'b0; cfg_len = '0; cfg_nocase = 1'b0; cfg_anchor = 1'b0;
    repeat (2) tick();
    check("reset match_pulse", 32'(match_pulse), 32'd0);
    check("reset match_alt", 32'(match_alt), 32'd0);
    check_state("reset", 1'b0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Alternation, case-insensitive
    cfg_nocase = 1'b1;
    prog(0, "<div></span>");
    prog(1, "<span></div>");
    add("^xx<DIV></span>", {"..........", "....1"});
    run_tbl();
    check_state("nocase", 1'b1, 13, 1);

    // Case-sensitive overlap; sod byte discarded
    cfg_nocase = 1'b0;
    prog(0, "aa");
    set_len(1, 0);
    add("^AaaaA", "...11.");
    run_tbl();
    check_state("overlap", 1'b1, 2, 2);

    // Anchored
    cfg_anchor = 1'b1;
    prog(0, "GET");
    add("^GET", "...1");
    run_tbl();
    check_state("anchor hit", 1'b1, 2, 1);
    add("^ GET", ".....");
    run_tbl();
    check_state("anchor miss", 1'b0, 0, 0);
    cfg_anchor = 1'b0;

    // sod mid-match, then en gaps inside a match with no re-fire during the hold
    prog(0, "<div></span>");
    prog(1, "<span></div>");
    add("^<div></spa^n>", {"..........", "...."});
    run_tbl();
    check_state("sod clear", 1'b0, 0, 0);
    add("^<div>__</span>__", {"..........", "....1.."});
    run_tbl();
    check_state("en gaps", 1'b1, 11, 1);

    // Multi-hot completion
    prog(0, "ab");
    prog(1, "b");
    add("^abb", "..32");
    run_tbl();
    check_state("multi-hot", 1'b1, 1, 2);

    // Length write on alt1 coincides with its completing byte: alt1 suppressed
    prog(1, "ab");
    step(1'b1, 1'b1, 8'h61, 2'd0);
    step(1'b0, 1'b1, 8'h61, 2'd0);
    cfg_len_we = 1'b1; cfg_alt = 1'b1; cfg_len = 5'd2;
    step(1'b0, 1'b1, 8'h62, 2'd1);
    add("ab", ".3");
    run_tbl();

    // Saturation, disabled alternative, out-of-range length ignored
    prog(0, "a");
    set_len(1, 0);
    set_len(0, 17);
    add("^aaaaaa", ".111111");
    run_tbl();
    check_state("sat wide", 1'b1, 0, 6);
    check("sat cnt2", 32'(cnt2), 32'd3);
    check("sat out2", 32'(out2), 32'd1);

    // Asynchronous reset while a pulse is up
    prog(0, "GET");
    add("^GET", "...1");
    run_tbl();
    check("pre-reset out", 32'(out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async match_pulse", 32'(match_pulse), 32'd0);
    check("async match_alt", 32'(match_alt), 32'd0);
    check_state("async", 1'b0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    add("^GETGET", ".......");
    run_tbl();
    check_state("post-reset", 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
